// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-limited sharing of one FIFO write port among NUM_REQ producers.
// Define FIFO_WR_ARB_STATS_EN to add per-requester saturating beat counters (stat_sel/stat_beats).
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    input  logic [ID_W-1:0]           stat_sel,
    output logic [7:0]                stat_beats
`endif
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t              state, state_nxt;
    logic [ID_W-1:0]     grant_nxt, rr_ptr, rr_nxt, pick;
    logic [3:0]          burst_cnt, cnt_nxt;
    logic                g_valid, g_last, xfer, release_now;
    logic [DATA_W-1:0]   g_data;

    // Second pass overrides the first, so the lowest index at or above rr_ptr wins, else the lowest below it.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        pick    = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
        for (int i = NUM_REQ-1; i >= 0; i--)
            if (req_valid[i] && ID_W'(i) < rr_ptr) pick = ID_W'(i);
        for (int i = NUM_REQ-1; i >= 0; i--)
            if (req_valid[i] && ID_W'(i) >= rr_ptr) pick = ID_W'(i);
    end

    always_comb begin
        busy = state == BURST;
        for (int i = 0; i < NUM_REQ; i++)
            req_ready[i] = busy && grant_id == ID_W'(i) && !fifo_full;
        xfer         = busy && g_valid && !fifo_full;
        fifo_wr_en   = xfer;
        fifo_wr_data = busy ? g_data : '0;
        release_now  = xfer ? (g_last || burst_cnt == 4'(MAX_BURST-1)) : (!g_valid && !fifo_full);
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        rr_nxt    = rr_ptr;
        cnt_nxt   = burst_cnt;
        if (state == IDLE) begin
            if (|req_valid) begin
                state_nxt = BURST;
                grant_nxt = pick;
                cnt_nxt   = '0;
            end
        end else begin
            cnt_nxt = xfer ? burst_cnt + 4'd1 : burst_cnt;
            if (release_now) begin
                state_nxt = IDLE;
                rr_nxt    = grant_id == ID_W'(NUM_REQ-1) ? '0 : grant_id + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant_id  <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant_id  <= grant_nxt;
            rr_ptr    <= rr_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [7:0] beats [NUM_REQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) beats[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (xfer && grant_id == ID_W'(i) && beats[i] != 8'hFF) beats[i] <= beats[i] + 8'd1;
        end
    end

    always_comb begin
        stat_beats = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (stat_sel == ID_W'(i)) stat_beats = beats[i];
    end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: random and directed traffic; a transaction-level round-robin model fills a scoreboard
// that a negedge monitor drains against every FIFO write.
module tb_fifo_wr_arbiter;
    localparam int N = 4, DW = 4, MB = 4, IW = 2;

    logic          clk = 0, rst = 1;
    logic [N-1:0]    req_valid = '0, req_last = '0, req_ready;
    logic [N*DW-1:0] req_data = '0;
    logic            fifo_full = 0, fifo_wr_en, busy;
    logic [DW-1:0]   fifo_wr_data;
    logic [IW-1:0]   grant_id;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [IW-1:0]   stat_sel = '0;
    logic [7:0]      stat_beats;
`endif

    int total = 0, bad = 0;
    logic [DW:0] mem [N][1024];
    int hd[N], tl[N], mh[N];
    int mptr = 0;
    logic [IW+DW-1:0] exp_q[$];
    logic [IW+DW-1:0] e_m;
    logic blog[64], wlog[64];
    logic [IW-1:0] glog[64];
    logic [N-1:0] rlog[64];
    int c;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .ID_W(IW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .grant_id(grant_id), .busy(busy)
`ifdef FIFO_WR_ARB_STATS_EN
        , .stat_sel(stat_sel), .stat_beats(stat_beats)
`endif
    );

    task automatic chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && fifo_wr_en) begin
            if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                e_m = exp_q.pop_front();
                chk("wr_grant_id", int'(grant_id), int'(e_m[IW+DW-1:DW]));
                chk("wr_data", int'(fifo_wr_data), int'(e_m[DW-1:0]));
            end
        end
    end

    // Producer obligation: a stalled granted beat stays put.
    logic [N-1:0] pv = '0, pr = '0;
    logic [N*DW-1:0] pd = '0;
    logic pb = 0;
    logic [IW-1:0] pg = '0;
    always @(negedge clk) begin
        if (!rst && pb && pv[pg] && !pr[pg])
            assert (req_valid[pg] && req_data[pg*DW +: DW] == pd[pg*DW +: DW])
                else $error("granted producer changed its beat while stalled");
        pv <= req_valid;
        pr <= req_ready;
        pd <= req_data;
        pb <= busy && !rst;
        pg <= grant_id;
    end

    task automatic push(int i, logic [DW-1:0] d, logic l);
        mem[i][tl[i] % 1024] = {l, d};
        tl[i]++;
    endtask

    task automatic present();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = hd[i] < tl[i];
            req_data[i*DW +: DW] = hd[i] < tl[i] ? mem[i][hd[i] % 1024][DW-1:0] : '0;
            req_last[i] = hd[i] < tl[i] && mem[i][hd[i] % 1024][DW];
        end
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (hd[i] < tl[i]) return 1;
        return 0;
    endfunction

    // Whole-burst view: serve the next non-empty producer from mptr, up to MB beats or through its last beat.
    task automatic model();
        int found, n;
        logic l;
        logic [IW+DW-1:0] e;
        while (1) begin
            found = -1;
            for (int k = 0; k < N; k++)
                if (found < 0 && mh[(mptr + k) % N] < tl[(mptr + k) % N]) found = (mptr + k) % N;
            if (found < 0) break;
            n = 0;
            while (1) begin
                e = {IW'(found), mem[found][mh[found] % 1024][DW-1:0]};
                exp_q.push_back(e);
                l = mem[found][mh[found] % 1024][DW];
                mh[found]++;
                n++;
                if (l || n == MB || mh[found] == tl[found]) break;
            end
            mptr = (found + 1) % N;
        end
    endtask

    task automatic run(int fs, int fl, int prob, output int cyc);
        logic [N-1:0] acc;
        cyc = 0;
        while ((pending() || exp_q.size() != 0) && cyc < 2000) begin
            fifo_full = (cyc >= fs && cyc < fs + fl) || ($urandom_range(99) < prob);
            @(negedge clk);
            if (cyc < 64) begin
                blog[cyc] = busy;
                wlog[cyc] = fifo_wr_en;
                glog[cyc] = grant_id;
                rlog[cyc] = req_ready;
            end
            acc = req_valid & req_ready;
            cyc++;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) if (acc[i]) hd[i]++;
            present();
        end
        if (cyc >= 2000) chk("run_timeout", cyc, 0);
        fifo_full = 0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            hd[i] = tl[i];
            mh[i] = tl[i];
        end
        exp_q.delete();
        mptr = 0;
        present();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rst_ready", int'(req_ready), 0);
            chk("rst_wr_en", int'(fifo_wr_en), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_grant", int'(grant_id), 0);
        end
        @(posedge clk);
        #1;

        // Single producer, three beats ending in last.
        push(0, 4'd1, 0); push(0, 4'd2, 0); push(0, 4'd3, 1);
        model(); present();
        run(0, 0, 0, c);
        chk("single_cycles", c, 4);
        chk("single_busy0", int'(blog[0]), 0);
        chk("single_busy1", int'(blog[1]), 1);
        chk("single_wr0", int'(wlog[0]), 0);
        chk("single_wr3", int'(wlog[3]), 1);

        // All four continuously valid, never last: 8 grants of MB beats, one idle cycle each.
        for (int i = 0; i < N; i++)
            for (int b = 0; b < 2 * MB; b++) push(i, 4'($urandom_range(15)), 0);
        model(); present();
        run(0, 0, 0, c);
        chk("rr_cycles", c, 2 * N * (MB + 1));

        // Requester 2 stalled by a full FIFO for five cycles after two beats.
        push(2, 4'd6, 0); push(2, 4'd7, 0); push(2, 4'd8, 0); push(2, 4'd9, 1);
        model(); present();
        run(3, 5, 0, c);
        chk("full_cycles", c, 10);
        for (int k = 3; k < 8; k++) begin
            chk("full_wr_en", int'(wlog[k]), 0);
            chk("full_ready", int'(rlog[k]), 0);
            chk("full_grant", int'(glog[k]), 2);
        end
        chk("full_resume", int'(wlog[8]), 1);

        // Asynchronous reset in the middle of a transfer cycle.
        for (int b = 0; b < 5; b++) push(3, 4'(b + 10), 0);
        model(); present();
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("arst_pre_wr", int'(fifo_wr_en), 1);
        rst = 1;
        #1;
        chk("arst_wr_en", int'(fifo_wr_en), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_grant", int'(grant_id), 0);
        chk("arst_data", int'(fifo_wr_data), 0);
        clear_all();
        @(posedge clk);
        #1 rst = 0;
        push(3, 4'd4, 0); push(3, 4'd5, 1);
        push(1, 4'd2, 0); push(1, 4'd3, 1);
        model(); present();
        run(0, 0, 0, c);
        chk("arst_drain", exp_q.size(), 0);

        // Random bursts with random backpressure.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(1) == 1) begin
                    int len = $urandom_range(1, 6);
                    bit use_last = $urandom_range(1) == 1;
                    for (int b = 0; b < len; b++)
                        push(i, 4'($urandom_range(15)), use_last && b == len - 1);
                end
            model(); present();
            run(0, 0, 30, c);
            chk("rand_drain", exp_q.size(), 0);
        end

`ifdef FIFO_WR_ARB_STATS_EN
        rst = 1;
        clear_all();
        @(posedge clk);
        #1 rst = 0;
        for (int b = 0; b < 3; b++) push(1, 4'(b), b == 2);
        for (int b = 0; b < 300; b++) push(0, 4'($urandom_range(15)), 0);
        model(); present();
        run(0, 0, 0, c);
        stat_sel = 1;
        #1 chk("stat_req1", int'(stat_beats), 3);
        stat_sel = 0;
        #1 chk("stat_req0_sat", int'(stat_beats), 255);
        stat_sel = 2;
        #1 chk("stat_req2", int'(stat_beats), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
